// File: rtl/fib_lpm_engine_if.sv
// Command/response bus of the FIB longest-prefix-match engine.
// Handshake: a transfer happens on a rising clk edge where both valid and
// ready are high; the offering side holds valid and its payload stable
// until that edge, and ready never depends combinationally on valid.
interface fib_lpm_engine_if #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int FACE_W   = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [PREFIX_W-1:0] cmd_prefix;
  logic [LEN_W-1:0]    cmd_len;
  logic [FACE_W-1:0]   cmd_face;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_hit;
  logic [LEN_W-1:0]    rsp_len;
  logic [FACE_W-1:0]   rsp_face;
  logic [PREFIX_W-1:0] rsp_prefix;
  logic                busy;

  modport master (
    output cmd_valid, cmd_op, cmd_prefix, cmd_len, cmd_face, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_len, rsp_face, rsp_prefix, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_prefix, cmd_len, cmd_face, rsp_ready,
    output cmd_ready, rsp_valid, rsp_hit, rsp_len, rsp_face, rsp_prefix, busy
  );
endinterface

// File: rtl/fib_lpm_engine.sv
// Hashed FIB with one bank per prefix length. Lookups walk from the requested
// length down to 0 (the default-route bank), two cycles per probed length.
// Entries carry no tag: equal length and equal hash alias one entry.
module fib_lpm_engine #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int IDX_W    = 10,
  parameter int FACE_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  fib_lpm_engine_if.slave  bus,
  output logic [2:0]       o_dbg_state
);
  localparam int NB = 1 << LEN_W;
  localparam int NE = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HASH  = 3'd1,
    S_PROBE = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t              r_state, w_next;
  logic [1:0]          r_op;
  logic [PREFIX_W-1:0] r_prefix;
  logic [LEN_W-1:0]    r_cur_len;
  logic [FACE_W-1:0]   r_face;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_cnt;
  logic                r_rsp_hit;
  logic [LEN_W-1:0]    r_rsp_len;
  logic [FACE_W-1:0]   r_rsp_face;
  logic                r_valid [NB][NE];
  logic [FACE_W-1:0]   r_fib_face [NB][NE];

  logic                w_accept;
  logic [IDX_W-1:0]    w_hash;
  logic                w_entry_valid;
  logic [FACE_W-1:0]   w_entry_face;
  logic                w_in_resp;

  assign w_accept      = bus.cmd_valid && (r_state == S_IDLE);
  assign w_entry_valid = r_valid[r_cur_len][r_idx];
  assign w_entry_face  = r_fib_face[r_cur_len][r_idx];
  assign w_in_resp     = (r_state == S_RESP);

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.rsp_valid  = w_in_resp;
  assign bus.rsp_hit    = w_in_resp ? r_rsp_hit  : 1'b0;
  assign bus.rsp_len    = w_in_resp ? r_rsp_len  : '0;
  assign bus.rsp_face   = w_in_resp ? r_rsp_face : '0;
  assign bus.rsp_prefix = w_in_resp ? r_prefix   : '0;
  assign o_dbg_state    = r_state;

  // Hash: keep prefix bits below cur_len, XOR-fold into IDX_W-bit chunks
  // (missing top bits of the last chunk act as zero padding), then mix in len.
  always_comb begin
    w_hash = '0;
    for (int i = 0; i < PREFIX_W; i++) begin
      if (i < int'(r_cur_len)) w_hash[i % IDX_W] = w_hash[i % IDX_W] ^ r_prefix[i];
    end
    for (int j = 0; j < LEN_W; j++) begin
      if (j < IDX_W) w_hash[j % IDX_W] = w_hash[j % IDX_W] ^ r_cur_len[j];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (bus.cmd_op == 2'b11) ? S_CLEAR : S_HASH;
      S_HASH:  w_next = (r_op == 2'b00) ? S_PROBE : S_WRITE;
      S_PROBE: if (w_entry_valid || (r_cur_len == '0)) w_next = S_RESP;
               else w_next = S_HASH;
      S_WRITE: w_next = S_RESP;
      S_CLEAR: if (r_cnt == '1) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture, length walk and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_prefix   <= '0;
      r_cur_len  <= '0;
      r_face     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_len  <= '0;
      r_rsp_face <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op      <= bus.cmd_op;
          r_prefix  <= bus.cmd_prefix;
          r_cur_len <= bus.cmd_len;
          r_face    <= bus.cmd_face;
          r_cnt     <= '0;
        end
        S_HASH: r_idx <= w_hash;
        S_PROBE: begin
          if (w_entry_valid) begin
            r_rsp_hit  <= 1'b1;
            r_rsp_len  <= r_cur_len;
            r_rsp_face <= w_entry_face;
          end else if (r_cur_len == '0) begin
            r_rsp_hit  <= 1'b0;
            r_rsp_len  <= '0;
            r_rsp_face <= '0;
          end else begin
            r_cur_len <= r_cur_len - 1'b1;
          end
        end
        S_WRITE: begin
          r_rsp_hit  <= (r_op == 2'b01) ? 1'b1 : w_entry_valid;
          r_rsp_len  <= r_cur_len;
          r_rsp_face <= '0;
        end
        S_CLEAR: begin
          r_cnt      <= r_cnt + 1'b1;
          r_rsp_hit  <= 1'b1;
          r_rsp_len  <= r_cur_len;
          r_rsp_face <= '0;
        end
        default: ;
      endcase
    end
  end

  // Table storage: insert/delete write one entry, clear wipes one index in all banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int e = 0; e < NE; e++) begin
          r_valid[b[LEN_W-1:0]][e[IDX_W-1:0]]    <= 1'b0;
          r_fib_face[b[LEN_W-1:0]][e[IDX_W-1:0]] <= '0;
        end
      end
    end else if (r_state == S_WRITE) begin
      r_valid[r_cur_len][r_idx]    <= (r_op == 2'b01);
      r_fib_face[r_cur_len][r_idx] <= (r_op == 2'b01) ? r_face : '0;
    end else if (r_state == S_CLEAR) begin
      for (int b = 0; b < NB; b++) begin
        r_valid[b[LEN_W-1:0]][r_cnt]    <= 1'b0;
        r_fib_face[b[LEN_W-1:0]][r_cnt] <= '0;
      end
    end
  end
endmodule
